// File: rtl/display_cmd_sched.sv
// display_cmd_sched: per-frame command word scheduler for a display link.
// Two requesters share one command slot per frame: a 4-deep register-write
// FIFO and a single-entry I2C line-level holding register. On each frame_req
// at most one of them is granted, round-robin. With no eligible requester, or
// with hold asserted, an idle word is sent instead. The I2C line levels are
// carried in every word so the far end always sees the current SDA/SCL state.
module display_cmd_sched (
  input  logic        c125,
  input  logic        reset,
  input  logic        frame_req,
  input  logic        hold,
  output logic [15:0] cmd,
  output logic        cmd_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        i2c_valid,
  output logic        i2c_ready,
  input  logic        i2c_sda,
  input  logic        i2c_scl,
  output logic [15:0] frame_count
);

  typedef enum logic {
    GRANT_WR  = 1'b0,
    GRANT_I2C = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'd0,
    ISSUE_WR   = 2'd1,
    ISSUE_I2C  = 2'd2
  } issue_e;

  localparam logic [15:0] CMD_RESET = 16'hC000;

  // Write FIFO storage: {addr, data}
  logic [11:0] fifo_mem_q [4];
  logic [11:0] fifo_mem_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;

  // I2C holding register and the line levels currently driven on the link
  logic        i2c_pend_q, i2c_pend_d;
  logic        i2c_sda_q, i2c_sda_d;
  logic        i2c_scl_q, i2c_scl_d;
  logic        sda_h_q, sda_h_d;
  logic        scl_h_q, scl_h_d;

  grant_e      last_grant_q, last_grant_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [15:0] frame_count_q, frame_count_d;

  issue_e      issue;
  logic        push;
  logic        pop;
  logic        i2c_accept;
  logic        fifo_nonempty;

  // Handshake readies come from registered state only, so a full FIFO that
  // pops this cycle still refuses a push until the count has actually dropped.
  assign wr_ready    = (count_q != 3'd4);
  assign i2c_ready   = ~i2c_pend_q;
  assign push        = wr_valid & wr_ready;
  assign i2c_accept  = i2c_valid & ~i2c_pend_q;

  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_count = frame_count_q;

  // Pick the requester for this frame; eligibility uses registered state only,
  // so anything accepted in the frame_req cycle waits for the next frame.
  always_comb begin
    issue         = ISSUE_IDLE;
    fifo_nonempty = (count_q != 3'd0);
    if (frame_req && !hold) begin
      if (fifo_nonempty && i2c_pend_q) begin
        issue = (last_grant_q == GRANT_I2C) ? ISSUE_WR : ISSUE_I2C;
      end else if (fifo_nonempty) begin
        issue = ISSUE_WR;
      end else if (i2c_pend_q) begin
        issue = ISSUE_I2C;
      end
    end
  end

  assign pop = (issue == ISSUE_WR);

  // FIFO push/pop bookkeeping
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {wr_addr, wr_data};
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // I2C request capture, line-level update on grant, and command word build
  always_comb begin
    i2c_pend_d    = i2c_pend_q;
    i2c_sda_d     = i2c_sda_q;
    i2c_scl_d     = i2c_scl_q;
    sda_h_d       = sda_h_q;
    scl_h_d       = scl_h_q;
    last_grant_d  = last_grant_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    frame_count_d = frame_count_q;

    // accept and grant are mutually exclusive: accept needs pend low, grant high
    if (i2c_accept) begin
      i2c_pend_d = 1'b1;
      i2c_sda_d  = i2c_sda;
      i2c_scl_d  = i2c_scl;
    end

    if (frame_req) begin
      cmd_valid_d   = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      case (issue)
        ISSUE_WR: begin
          cmd_d        = {sda_h_q, scl_h_q, 1'b0, 1'b1, fifo_mem_q[rd_ptr_q]};
          last_grant_d = GRANT_WR;
        end
        ISSUE_I2C: begin
          cmd_d        = {i2c_sda_q, i2c_scl_q, 14'h0000};
          sda_h_d      = i2c_sda_q;
          scl_h_d      = i2c_scl_q;
          i2c_pend_d   = 1'b0;
          last_grant_d = GRANT_I2C;
        end
        default: begin
          cmd_d = {sda_h_q, scl_h_q, 14'h0000};
        end
      endcase
    end
  end

  // State registers; reset drops any queued work and releases both lines
  always_ff @(posedge c125 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 12'h000;
      end
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      i2c_pend_q    <= 1'b0;
      i2c_sda_q     <= 1'b1;
      i2c_scl_q     <= 1'b1;
      sda_h_q       <= 1'b1;
      scl_h_q       <= 1'b1;
      last_grant_q  <= GRANT_I2C;
      cmd_q         <= CMD_RESET;
      cmd_valid_q   <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      fifo_mem_q    <= fifo_mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      i2c_pend_q    <= i2c_pend_d;
      i2c_sda_q     <= i2c_sda_d;
      i2c_scl_q     <= i2c_scl_d;
      sda_h_q       <= sda_h_d;
      scl_h_q       <= scl_h_d;
      last_grant_q  <= last_grant_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_display_cmd_sched.sv
// Bench for display_cmd_sched: directed scenarios followed by random traffic,
// all checked against a queue-based model of the scheduling rules.
module tb_display_cmd_sched;

  logic        c125 = 1'b0;
  logic        reset;
  logic        frame_req;
  logic        hold;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        i2c_valid;
  logic        i2c_ready;
  logic        i2c_sda;
  logic        i2c_scl;
  logic [15:0] frame_count;

  display_cmd_sched dut (
    .c125       (c125),
    .reset      (reset),
    .frame_req  (frame_req),
    .hold       (hold),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .i2c_valid  (i2c_valid),
    .i2c_ready  (i2c_ready),
    .i2c_sda    (i2c_sda),
    .i2c_scl    (i2c_scl),
    .frame_count(frame_count)
  );

  always #4 c125 = ~c125;

  // Reference model state
  logic [11:0] m_q[$];
  bit          m_pend;
  bit          m_rs, m_rc;
  bit          m_sh, m_sc;
  bit          m_last_i2c;
  logic [15:0] m_cmd;
  bit          m_valid;
  logic [15:0] m_fc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend     = 0;
    m_rs       = 1;
    m_rc       = 1;
    m_sh       = 1;
    m_sc       = 1;
    m_last_i2c = 1;
    m_cmd      = 16'hC000;
    m_valid    = 0;
    m_fc       = 16'd0;
  endtask

  // One clock cycle: drive, check readies before the edge, advance, check outputs.
  task automatic cyc(input bit fr, input bit hd, input bit wv, input logic [3:0] wa,
                     input logic [7:0] wd, input bit iv, input bit isda, input bit iscl);
    bit do_wr, do_i2c, push, acc;
    frame_req = fr;
    hold      = hd;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    i2c_valid = iv;
    i2c_sda   = isda;
    i2c_scl   = iscl;
    #1;
    chk("wr_ready", 16'(wr_ready), 16'(m_q.size() < 4));
    chk("i2c_ready", 16'(i2c_ready), 16'(!m_pend));
    push   = wv && (m_q.size() < 4);
    acc    = iv && !m_pend;
    do_wr  = 0;
    do_i2c = 0;
    if (fr && !hd) begin
      if (m_q.size() > 0 && m_pend) begin
        if (m_last_i2c) do_wr = 1;
        else do_i2c = 1;
      end else if (m_q.size() > 0) begin
        do_wr = 1;
      end else if (m_pend) begin
        do_i2c = 1;
      end
    end
    @(posedge c125);
    #1;
    m_valid = fr;
    if (fr) m_fc = m_fc + 16'd1;
    if (do_wr) begin
      m_cmd      = {m_sh, m_sc, 1'b0, 1'b1, m_q.pop_front()};
      m_last_i2c = 0;
    end else if (do_i2c) begin
      m_sh       = m_rs;
      m_sc       = m_rc;
      m_cmd      = {m_sh, m_sc, 14'h0000};
      m_pend     = 0;
      m_last_i2c = 1;
    end else if (fr) begin
      m_cmd = {m_sh, m_sc, 14'h0000};
    end
    if (push) m_q.push_back({wa, wd});
    if (acc) begin
      m_pend = 1;
      m_rs   = isda;
      m_rc   = iscl;
    end
    chk("cmd", cmd, m_cmd);
    chk("cmd_valid", 16'(cmd_valid), 16'(m_valid));
    chk("frame_count", frame_count, m_fc);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 4'h0, 8'h00, 0, 1, 1);
  endtask

  task automatic frame(input bit hd);
    cyc(1, hd, 0, 4'h0, 8'h00, 0, 1, 1);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    cyc(0, 0, 1, a, d, 0, 1, 1);
  endtask

  // Reset is raised between edges and its effect checked before the next edge.
  task automatic do_reset();
    frame_req = 0;
    hold      = 0;
    wr_valid  = 0;
    i2c_valid = 0;
    #1;
    reset = 1;
    #1;
    chk("rst_cmd", cmd, 16'hC000);
    chk("rst_cmd_valid", 16'(cmd_valid), 16'h0);
    chk("rst_wr_ready", 16'(wr_ready), 16'h1);
    chk("rst_i2c_ready", 16'(i2c_ready), 16'h1);
    chk("rst_frame_count", frame_count, 16'h0);
    model_reset();
    @(posedge c125);
    #1;
    reset = 0;
  endtask

  initial begin
    reset     = 1;
    frame_req = 0;
    hold      = 0;
    wr_valid  = 0;
    wr_addr   = 0;
    wr_data   = 0;
    i2c_valid = 0;
    i2c_sda   = 1;
    i2c_scl   = 1;
    model_reset();
    repeat (2) @(posedge c125);
    #1;
    reset = 0;
    idle(2);

    // Idle word after reset, one-cycle valid
    frame(0);
    chk("idle_word", cmd, 16'hC000);
    chk("idle_fc", frame_count, 16'd1);
    idle(1);
    chk("idle_valid_drop", 16'(cmd_valid), 16'h0);

    // Single write, then idle that keeps the line levels
    push_wr(4'h3, 8'hA5);
    frame(0);
    chk("write_word", cmd, 16'hD3A5);
    frame(0);
    chk("write_then_idle", cmd, 16'hC000);
    idle(2);

    // Fairness: writes win first after reset, then alternate
    do_reset();
    push_wr(4'h1, 8'h11);
    push_wr(4'h2, 8'h22);
    push_wr(4'h4, 8'h44);
    cyc(0, 0, 0, 4'h0, 8'h00, 1, 0, 1);
    idle(1);
    frame(0);
    chk("fair_wr0", cmd, 16'hD111);
    frame(0);
    chk("fair_i2c", cmd, 16'h4000);
    frame(0);
    chk("fair_wr1", cmd, 16'h5222);
    frame(0);
    chk("fair_wr2", cmd, 16'h5444);
    idle(1);

    // Full FIFO: fifth push waits for a pop, order kept
    do_reset();
    push_wr(4'h5, 8'h01);
    push_wr(4'h6, 8'h02);
    push_wr(4'h7, 8'h03);
    push_wr(4'h8, 8'h04);
    chk("full_ready", 16'(wr_ready), 16'h0);
    push_wr(4'h9, 8'h05);
    cyc(1, 0, 1, 4'h9, 8'h05, 0, 1, 1);
    chk("full_pop_word", cmd, 16'hD501);
    push_wr(4'h9, 8'h05);
    for (int k = 0; k < 4; k++) frame(0);
    chk("full_last_word", cmd, 16'hD905);
    idle(1);

    // Hold with both requesters pending, then no-bypass
    do_reset();
    push_wr(4'hA, 8'hBC);
    cyc(0, 0, 0, 4'h0, 8'h00, 1, 0, 0);
    frame(1);
    chk("hold_idle", cmd, 16'hC000);
    frame(0);
    chk("hold_then_wr", cmd, 16'hDABC);
    frame(0);
    chk("hold_then_i2c", cmd, 16'h0000);
    cyc(1, 0, 1, 4'hE, 8'h77, 0, 1, 1);
    chk("nobypass_idle", cmd, 16'h0000);
    frame(0);
    chk("nobypass_wr", cmd, 16'h1E77);
    frame(1);
    idle(1);

    // Reset mid-queue discards writes
    push_wr(4'h1, 8'h01);
    push_wr(4'h2, 8'h02);
    do_reset();
    idle(1);
    frame(0);
    chk("post_reset_idle", cmd, 16'hC000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1), 4'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end

    // Frame counter wraps after 65536 frames
    do_reset();
    for (int k = 0; k < 65535; k++) frame($urandom_range(0, 1) == 1);
    chk("fc_ffff", frame_count, 16'hFFFF);
    frame(0);
    chk("fc_wrap", frame_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_cmd_sched.md
DISPLAY_CMD_SCHED -- requirements
Module: display_cmd_sched

Interface
REQ-001 SHALL provide one clock and one reset: the reset is asynchronous and active-high; the ports are listed below.
REQ-002 Port: c125  in  1  link-side clock, 125 MHz; all logic on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high.
REQ-004 Port: frame_req  in  1  one-cycle pulse; link needs the next command word for the upcoming frame.
REQ-005 Port: hold  in  1  when high at frame_req, issue an idle word; grant nothing.
REQ-006 Port: cmd  out  16  command word, registered: [15] sda_t, [14] scl_t, [13] reserved 0, [12] write strobe, [11:8] addr, [7:0] wdata.
REQ-007 Port: cmd_valid  out  1  one-cycle pulse qualifying cmd.
REQ-008 Port: wr_valid / wr_ready  in / out  1 / 1  register-write requester handshake; transfer when both are high.
REQ-009 Port: wr_addr, wr_data  in  4, 8  register-write payload.
REQ-010 Port: i2c_valid / i2c_ready  in / out  1 / 1  I2C bit-bang requester handshake.
REQ-011 Port: i2c_sda, i2c_scl  in  1, 1  requested target line tristate levels (1 = released).
REQ-012 Port: frame_count  out  16  count of frame_req pulses serviced; wraps.

Function
REQ-013 Writes SHALL enter a 4-entry FIFO; wr_ready = 1 when FIFO count < 4, computed from the registered count only; a full FIFO that pops in the same cycle keeps wr_ready = 0 for that cycle.
REQ-014 I2C requests SHALL enter a 1-entry holding register; i2c_ready = !i2c_pend.
REQ-015 At most one requester SHALL be granted per frame_req; a write and an I2C change are never combined in one word.
REQ-016 Eligibility: FIFO non-empty / i2c_pend high, sampled from registered state at the frame_req cycle; no bypass, so an entry accepted on the frame_req cycle is not eligible for that frame.
REQ-017 Arbitration: round-robin via a last_grant flag (reset value = I2C, so writes win first); if only one requester is eligible, grant it; if none, or if hold = 1, issue an idle word.
REQ-018 Write grant: cmd = {sda_h, scl_h, 0, 1, addr, data}; FIFO pops; last_grant <= WR.
REQ-019 I2C grant: sda_h/scl_h <= the requested levels; cmd = {new sda, new scl, 0, 0, 12'h000}; i2c_pend clears; last_grant <= I2C.
REQ-020 Idle word: cmd = {sda_h, scl_h, 14'h0000}; requester state and last_grant are unchanged.
REQ-021 Latency: cmd and cmd_valid SHALL update on the edge after the frame_req cycle (1 cycle); cmd holds its value until the next grant.
REQ-022 Back-to-back frame_req pulses (consecutive cycles) SHALL each be serviced independently, one word per pulse.
REQ-023 FIFO push and pop in the same cycle SHALL leave the count unchanged; data order SHALL be strict FIFO.
REQ-024 i2c_valid high while i2c_pend = 1 SHALL NOT be accepted; the requester holds until ready.
REQ-025 frame_count SHALL increment on every serviced frame_req, including idle and hold words; 16'hFFFF wraps to 0.

Reset
REQ-026 On reset assertion, the block SHALL immediately force:
- cmd = 16'hC000, cmd_valid = 0;
- sda_h = scl_h = 1;
- FIFO empty, wr_ready = 1;
- i2c_pend = 0, i2c_ready = 1;
- last_grant = I2C, frame_count = 0.
REQ-027 A reset asserted mid-operation SHALL discard queued writes and any pending I2C request; nothing is issued after deassertion until a new frame_req.

Verification
REQ-028 Idle: after reset, frame_req with no requests -> next cycle cmd = 16'hC000, cmd_valid = 1 for exactly one cycle, frame_count = 1.
REQ-029 Write: push addr 4'h3, data 8'hA5, then frame_req -> cmd = 16'hD3A5; a second frame_req -> cmd = 16'hC000.
REQ-030 Fairness: with 3 writes queued and i2c (sda = 0, scl = 1) pending, 4 frame_reqs -> the words SHALL be, in order:
- WR0 = 16'hD_xx (bits 15:14 = 11);
- I2C = 16'h4000;
- WR1 with bits 15:14 = 01;
- WR2 with bits 15:14 = 01.
REQ-031 Full: push 5 writes back-to-back -> wr_ready = 0 after the 4th push; the 5th transfer SHALL wait until a pop; order SHALL be preserved.
REQ-032 Hold and no-bypass:
- hold = 1 with both requesters pending -> idle word, no state change.
- A write pushed on the frame_req cycle into an empty FIFO -> idle word for that frame, and the write is issued on the next frame_req.
REQ-033 Reset mid-queue: with 2 writes queued, assert reset -> cmd = 16'hC000 immediately; after deassertion, frame_req -> idle word; frame_count wraps after 65536 frame_reqs.
